// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - send/receive sequencer with direction turnaround for a three-state bus stage
module bus_xfer_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TURNAROUND = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  snd_en,
    output logic                  rcv_en,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_SEND,
        ST_RECV
    } state_t;

    // Counter preload; TURN is never entered when the gap is zero
    localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam bit         HAS_TURN  = (TURNAROUND > 0);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            turn_cnt;
    logic                  hist_valid;
    logic                  hist_write;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  handshake;
    logic                  need_turn;
    logic                  req_ready_nxt;
    logic                  snd_en_nxt;
    logic                  rcv_en_nxt;
    logic                  done_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

    assign handshake = req_valid & req_ready;
    assign need_turn = HAS_TURN && hist_valid && (hist_write != req_write);

    // State, bookkeeping and registered outputs; reset drops any in-flight transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            turn_cnt   <= 4'd0;
            hist_valid <= 1'b0;
            hist_write <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            snd_en     <= 1'b0;
            rcv_en     <= 1'b0;
            done       <= 1'b0;
            out_data   <= '0;
            rsp_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= req_ready_nxt;
            snd_en    <= snd_en_nxt;
            rcv_en    <= rcv_en_nxt;
            done      <= done_nxt;
            out_data  <= out_data_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            if (handshake) begin
                wr_q     <= req_write;
                wdata_q  <= req_wdata;
                turn_cnt <= TURN_LOAD;
            end else if (state == ST_TURN && turn_cnt != 4'd0) begin
                turn_cnt <= turn_cnt - 4'd1;
            end
            if (state == ST_SEND) begin
                hist_valid <= 1'b1;
                hist_write <= 1'b1;
            end else if (state == ST_RECV) begin
                hist_valid <= 1'b1;
                hist_write <= 1'b0;
            end
        end
    end

    // Next state: insert TURN only when the bus direction flips
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    if (need_turn)      state_nxt = ST_TURN;
                    else if (req_write) state_nxt = ST_SEND;
                    else                state_nxt = ST_RECV;
                end
            end
            ST_TURN: begin
                if (turn_cnt == 4'd0) state_nxt = wr_q ? ST_SEND : ST_RECV;
            end
            ST_SEND: state_nxt = ST_IDLE;
            ST_RECV: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the next cycle, decoded from the state being entered
    always_comb begin
        req_ready_nxt = (state_nxt == ST_IDLE);
        snd_en_nxt    = (state_nxt == ST_SEND);
        rcv_en_nxt    = (state_nxt == ST_RECV);
        done_nxt      = (state == ST_SEND) || (state == ST_RECV);
        out_data_nxt  = out_data;
        rsp_rdata_nxt = rsp_rdata;
        if (state_nxt == ST_SEND) begin
            out_data_nxt = (state == ST_IDLE) ? req_wdata : wdata_q;
        end
        if (state == ST_RECV) begin
            rsp_rdata_nxt = in_data;
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_ready, a_write, a_snd, a_rcv, a_done;
    logic [31:0] a_wdata, a_out, a_in, a_rsp;
    logic        b_valid, b_ready, b_write, b_snd, b_rcv, b_done;
    logic [31:0] b_wdata, b_out, b_in, b_rsp;

    int checks = 0;
    int errors = 0;

    bit mon_en = 1'b0;
    int mon_last = -1;
    int mon_low = 0;
    int mon_dir = 0;
    int done_cnt = 0;

    bus_xfer_ctrl #(.DATA_WIDTH(32), .TURNAROUND(1)) dut_t1 (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_write(a_write), .req_wdata(a_wdata), .snd_en(a_snd), .rcv_en(a_rcv),
        .out_data(a_out), .in_data(a_in), .done(a_done), .rsp_rdata(a_rsp)
    );

    bus_xfer_ctrl #(.DATA_WIDTH(32), .TURNAROUND(3)) dut_t3 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_write(b_write), .req_wdata(b_wdata), .snd_en(b_snd), .rcv_en(b_rcv),
        .out_data(b_out), .in_data(b_in), .done(b_done), .rsp_rdata(b_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    // Bus-level scoreboard for the TURNAROUND=3 instance
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (b_snd && b_rcv) begin
                errors++;
                $display("FAIL exclusive_enables: snd_en=%b rcv_en=%b, required not both 1", b_snd, b_rcv);
            end
            if (b_done) done_cnt++;
            if (b_snd || b_rcv) begin
                mon_dir = b_snd ? 1 : 0;
                if (mon_last >= 0 && mon_dir != mon_last) begin
                    checks++;
                    if (mon_low < 4) begin
                        errors++;
                        $display("FAIL turn_gap: %0d idle cycles, required at least 4", mon_low);
                    end
                end
                mon_last = mon_dir;
                mon_low = 0;
            end else begin
                mon_low++;
            end
        end
    end

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", a_ready); end
        checks++; if (a_snd !== 1'b0) begin errors++; $display("FAIL reset_snd: got %b required 0", a_snd); end
        checks++; if (a_rcv !== 1'b0) begin errors++; $display("FAIL reset_rcv: got %b required 0", a_rcv); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", a_done); end
        checks++; if (a_out !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h required 0", a_out); end
        checks++; if (a_rsp !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h required 0", a_rsp); end
        checks++;
        if ({b_ready, b_snd, b_rcv, b_done, b_out, b_rsp} !== {1'b1, 3'b000, 64'h0}) begin
            errors++;
            $display("FAIL reset_t3: got ready=%b snd=%b rcv=%b done=%b out=%h rsp=%h required 1 0 0 0 0 0",
                     b_ready, b_snd, b_rcv, b_done, b_out, b_rsp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_send();
        logic [31:0] w;
        w = 32'hA5A5A5A5;
        a_valid = 1'b1; a_write = 1'b1; a_wdata = w;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b required 1", a_ready); end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_snd !== 1'b1) begin errors++; $display("FAIL first_snd: got %b required 1", a_snd); end
        checks++; if (a_out !== w) begin errors++; $display("FAIL first_out_data: got %h required %h", a_out, w); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL first_done_early: got %b required 0", a_done); end
        @(negedge clk);
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL first_done: got %b required 1", a_done); end
        checks++; if (a_snd !== 1'b0) begin errors++; $display("FAIL first_snd_fall: got %b required 0", a_snd); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL first_ready_back: got %b required 1", a_ready); end
    endtask

    task automatic test_dir_change();
        logic [31:0] r;
        r = 32'h5A5A5A5A;
        a_valid = 1'b1; a_write = 1'b0; a_in = 32'hFFFF0000;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if ({a_snd, a_rcv} !== 2'b00) begin errors++; $display("FAIL turn_enables: got %b required 00", {a_snd, a_rcv}); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL turn_done: got %b required 0", a_done); end
        @(negedge clk);
        checks++; if ({a_snd, a_rcv} !== 2'b01) begin errors++; $display("FAIL recv_enables: got %b required 01", {a_snd, a_rcv}); end
        a_in = r;
        @(negedge clk);
        a_in = 32'h0;
        checks++; if (a_rcv !== 1'b0) begin errors++; $display("FAIL recv_one_cycle: got %b required 0", a_rcv); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL recv_done: got %b required 1", a_done); end
        checks++; if (a_rsp !== r) begin errors++; $display("FAIL recv_rsp_rdata: got %h required %h", a_rsp, r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0, w1;
        int first, second;
        w0 = 32'h12345678; w1 = 32'h87654321;
        first = -1; second = -1;
        a_valid = 1'b1; a_write = 1'b1; a_wdata = w0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_snd === 1'b1) begin
                if (first < 0) begin
                    first = c;
                    checks++; if (a_out !== w0) begin errors++; $display("FAIL b2b_out0: got %h required %h", a_out, w0); end
                    a_wdata = w1;
                end else if (second < 0) begin
                    second = c;
                    checks++; if (a_out !== w1) begin errors++; $display("FAIL b2b_out1: got %h required %h", a_out, w1); end
                    a_valid = 1'b0;
                end
            end
        end
        a_valid = 1'b0;
        checks++; if (first !== 1) begin errors++; $display("FAIL b2b_first_cycle: got %0d required 1", first); end
        checks++; if (second - first !== 2) begin errors++; $display("FAIL b2b_spacing: got %0d required 2", second - first); end
        checks++; if (a_out !== w1) begin errors++; $display("FAIL b2b_out_hold: got %h required %h", a_out, w1); end
    endtask

    task automatic test_reset_recv();
        a_valid = 1'b1; a_write = 1'b1; a_wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_rcv !== 1'b1) begin errors++; $display("FAIL rstrecv_pre: got %b required 1", a_rcv); end
        a_in = 32'hDEADBEEF;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (a_rcv !== 1'b0) begin errors++; $display("FAIL rstrecv_rcv: got %b required 0", a_rcv); end
        checks++; if (a_rsp !== 32'h0) begin errors++; $display("FAIL rstrecv_rsp: got %h required 0", a_rsp); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rstrecv_ready: got %b required 1", a_ready); end
        @(negedge clk);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rstrecv_done: got %b required 0", a_done); end
        rst_n = 1'b1;
        a_valid = 1'b1; a_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_rcv !== 1'b1) begin errors++; $display("FAIL rstrecv_no_turn: got %b required 1", a_rcv); end
        a_in = 32'h0BADF00D;
        @(negedge clk);
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL rstrecv_done2: got %b required 1", a_done); end
        checks++; if (a_rsp !== 32'h0BADF00D) begin errors++; $display("FAIL rstrecv_rsp2: got %h required 0badf00d", a_rsp); end
    endtask

    task automatic test_random_mix();
        int hist, lat, gap, accepted;
        logic wr;
        logic [31:0] wd, rd, exp_out, exp_rsp;
        hist = -1; accepted = 0; exp_out = 32'h0; exp_rsp = 32'h0;
        mon_last = -1; mon_low = 0; done_cnt = 0;
        mon_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            gap = $urandom_range(0, 2);
            b_valid = 1'b0;
            repeat (gap) @(negedge clk);
            b_valid = 1'b1; b_write = wr; b_wdata = wd;
            checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready n=%0d: got %b required 1", n, b_ready); end
            @(posedge clk);
            accepted++;
            lat = (hist >= 0 && hist != int'(wr)) ? 4 : 1;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                b_valid = 1'b0;
                if (k < lat) begin
                    b_in = $urandom;
                    checks++; if ({b_snd, b_rcv} !== 2'b00) begin errors++; $display("FAIL rnd_turn n=%0d k=%0d: got %b required 00", n, k, {b_snd, b_rcv}); end
                end else begin
                    checks++; if ({b_snd, b_rcv} !== {wr, ~wr}) begin errors++; $display("FAIL rnd_enable n=%0d: got %b required %b", n, {b_snd, b_rcv}, {wr, ~wr}); end
                    if (wr) begin
                        exp_out = wd;
                        checks++; if (b_out !== exp_out) begin errors++; $display("FAIL rnd_out n=%0d: got %h required %h", n, b_out, exp_out); end
                    end else begin
                        rd = $urandom;
                        b_in = rd;
                        exp_rsp = rd;
                    end
                end
            end
            @(negedge clk);
            b_in = $urandom;
            checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL rnd_done n=%0d: got %b required 1", n, b_done); end
            checks++; if (b_rsp !== exp_rsp) begin errors++; $display("FAIL rnd_rsp n=%0d: got %h required %h", n, b_rsp, exp_rsp); end
            checks++; if (b_out !== exp_out) begin errors++; $display("FAIL rnd_out_hold n=%0d: got %h required %h", n, b_out, exp_out); end
            hist = int'(wr);
        end
        b_valid = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        checks++; if (done_cnt !== accepted) begin errors++; $display("FAIL rnd_done_count: got %0d required %0d", done_cnt, accepted); end
    endtask

    initial begin
        rst_n = 1'b1;
        a_valid = 1'b0; a_write = 1'b0; a_wdata = 32'h0; a_in = 32'h0;
        b_valid = 1'b0; b_write = 1'b0; b_wdata = 32'h0; b_in = 32'h0;
        test_reset();
        test_first_send();
        test_dir_change();
        test_back_to_back();
        @(negedge clk);
        test_reset();
        test_reset_recv();
        test_random_mix();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Sequencing controller that sits directly upstream of the `three_state_bus` stage on the shared 32-bit data bus. It accepts one send or receive request at a time over a valid/ready handshake. It generates the mutually exclusive `snd_en`/`rcv_en` enables and the `out_data` word that feed the three-state stage. On receives it captures `in_data` and returns it with a completion pulse. A programmable turnaround gap separates direction changes, so the bus is never driven from both sides.

## Interface
- `DATA_WIDTH`, default 32: width of every data path.
- `TURNAROUND`, default 1: idle cycles, with both enables low, inserted before a transfer whose direction differs from the previous one. Legal range is 0..15.

- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: controller can accept a request.
- `req_write`, in, 1: 1 = send (drive bus), 0 = receive (sample bus).
- `req_wdata`, in, DATA_WIDTH: word to send; sampled only at the handshake.
- `snd_en`, out, 1: drives the three-state stage's send enable.
- `rcv_en`, out, 1: drives the three-state stage's receive enable.
- `out_data`, out, DATA_WIDTH: word presented to the three-state stage.
- `in_data`, in, DATA_WIDTH: word returned from the three-state stage.
- `done`, out, 1: one-cycle completion pulse, for both sends and receives.
- `rsp_rdata`, out, DATA_WIDTH: last received word.

## Operation
- The FSM has four states: IDLE, TURN, SEND and RECV.
- All outputs are registered.
- Reset values: state = IDLE, `req_ready` = 1, `snd_en` = 0, `rcv_en` = 0, `out_data` = 0, `done` = 0, `rsp_rdata` = 0, turnaround counter = 0, direction history = "none".
- `req_ready` is 1 only in IDLE. A handshake is `req_valid & req_ready` at a rising edge; at that edge `req_write` and `req_wdata` are latched.
- Next state after the handshake:
  - TURN, if the history is valid, the direction differs and `TURNAROUND` > 0. The counter loads `TURNAROUND-1` and TURN holds until it reaches 0.
  - Otherwise SEND or RECV directly.
- SEND lasts exactly one cycle:
  - `snd_en` = 1 and `out_data` = latched word.
  - Next state is IDLE; history is set to "send".
- RECV lasts exactly one cycle:
  - `rcv_en` = 1.
  - At the edge ending RECV, `in_data` is captured into `rsp_rdata`.
  - Next state is IDLE; history is set to "receive".
- `done` pulses high in the cycle after SEND or RECV, coinciding with the return to IDLE.
- `out_data` holds its last sent value outside SEND. `rsp_rdata` holds until the next receive; it is unchanged by sends.
- Invariants:
  - `snd_en & rcv_en` is never 1.
  - Between the falling of one enable and the rising of the opposite enable there are at least `TURNAROUND` cycles with both low, in addition to the IDLE cycle.
- The first transfer after reset never incurs turnaround.
- `req_valid` while not ready is ignored and needs no buffering; the requester must hold its request until the handshake.

## Timing
- Handshake at edge E0.
- Same-direction or first transfer: enable is high in cycle E0+1, `done` is high in cycle E0+2, and `req_ready` is 1 again in E0+2.
- Direction change: TURN occupies cycles E0+1 .. E0+`TURNAROUND`. The enable is high in cycle E0+`TURNAROUND`+1 and `done` one cycle later.
- Maximum throughput is one transfer per 2 cycles for the same direction.
- Read data is valid in `rsp_rdata` in the same cycle as `done`.
- Reset mid-operation (any state): all outputs return to their reset values asynchronously. The in-flight transfer is dropped with no `done` pulse, and the history returns to "none".
- A handshake in the `done` cycle is legal, since IDLE has `req_ready` = 1; `done` and the next transfer's latch coincide without interference.

## Test plan
- Reset check: assert `rst_n` = 0 mid-simulation. Required: `snd_en` = `rcv_en` = `done` = 0, `out_data` = 0, `rsp_rdata` = 0 and `req_ready` = 1, all immediately without waiting for a clock edge.
- First send after reset, `req_wdata` = 0xA5A5A5A5. Required: `snd_en` = 1 and `out_data` = 0xA5A5A5A5 in cycle E0+1, then `done` in E0+2, with no TURN.
- Direction change with `TURNAROUND` = 1: the send above, then a receive with `in_data` = 0x5A5A5A5A. Required: exactly one TURN cycle with both enables low; `rcv_en` = 1 for one cycle; `rsp_rdata` = 0x5A5A5A5A together with `done`.
- Back-to-back sends 0x12345678 then 0x87654321 with `req_valid` held. Required: `snd_en` pulses exactly 2 cycles apart, no TURN, and `out_data` follows each word.
- Reset during RECV: assert `rst_n` = 0 while `rcv_en` = 1. Required: `rcv_en` drops immediately, no `done` pulse, and `rsp_rdata` = 0. The next receive after release incurs no turnaround.
- `TURNAROUND` = 3 with random send/receive mixes of 200 transfers. Required: the scoreboard confirms `snd_en` and `rcv_en` are never high together and the opposite-direction gap is at least 3 cycles. Every `done` matches one accepted request, and every received word equals the `in_data` value driven in its RECV cycle.
